// File: rtl/hermes_packetizer_pkg.sv
// Constants shared between the Hermes network interface and the switch routing logic.
package HermesPkg;

  localparam int HERMES_TARGET_WIDTH = 16;

endpackage

// File: rtl/hermes_packetizer.sv
// Hermes NI injection stage: turns a request plus a payload stream into
// header/size/payload flits on the credit-based LOCAL link of a router.
module hermes_packetizer
  import HermesPkg::*;
#(
  parameter int FLIT_SIZE = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [HERMES_TARGET_WIDTH-1:0] req_target_i,
  input  logic [FLIT_SIZE-1:0]           req_size_i,
  input  logic                           pl_valid_i,
  output logic                           pl_ready_o,
  input  logic [FLIT_SIZE-1:0]           pl_data_i,
  output logic                           tx_o,
  input  logic                           credit_i,
  output logic [FLIT_SIZE-1:0]           data_o,
  output logic                           busy_o,
  output logic                           pkt_sent_o
);

  typedef enum logic [1:0] {IDLE, SIZE, PAYLOAD} state_t;

  localparam logic [FLIT_SIZE-1:0] COUNT_ONE = FLIT_SIZE'(1);

  state_t                 state_q, state_d;
  logic [FLIT_SIZE-1:0]   count_q, count_d;
  logic [FLIT_SIZE-1:0]   data_q, data_d;
  logic                   tx_q, tx_d;
  logic                   last_q, last_d;
  logic                   slot_free;

  // The single output slot can take a new flit if empty or draining this cycle.
  assign slot_free = !tx_q || credit_i;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    data_d      = data_q;
    tx_d        = tx_q && !credit_i;
    last_d      = last_q;
    req_ready_o = 1'b0;
    pl_ready_o  = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = slot_free;
        if (req_valid_i && slot_free) begin
          data_d                           = '0;
          data_d[HERMES_TARGET_WIDTH-1:0]  = req_target_i;
          tx_d                             = 1'b1;
          last_d                           = 1'b0;
          count_d                          = req_size_i;
          state_d                          = SIZE;
        end
      end

      SIZE: begin
        if (slot_free) begin
          data_d = count_q;
          tx_d   = 1'b1;
          if (count_q == '0) begin
            last_d  = 1'b1;
            state_d = IDLE;
          end else begin
            last_d  = 1'b0;
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        pl_ready_o = slot_free;
        if (pl_valid_i && slot_free) begin
          data_d  = pl_data_i;
          tx_d    = 1'b1;
          count_d = count_q - COUNT_ONE;
          if (count_q == COUNT_ONE) begin
            last_d  = 1'b1;
            state_d = IDLE;
          end else begin
            last_d  = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
      tx_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      last_q  <= last_d;
    end
  end

  assign tx_o       = tx_q;
  assign data_o     = data_q;
  assign busy_o     = (state_q != IDLE) || tx_q;
  assign pkt_sent_o = tx_q && credit_i && last_q;

endmodule

// File: doc/hermes_packetizer.md
Name: hermes_packetizer

Overview:
- Network-interface injection stage that feeds a Hermes router's LOCAL input port (drives its rx/data, consumes its credit).
- Accepts a packet request (target address + payload length) and a payload flit stream, and emits Hermes packets on the credit-based link.
- Packet format on the link: header flit (target), size flit (payload flit count), then the payload flits.

Parameters:
- FLIT_SIZE, 32, flit width in bits (minimum 16).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- req_valid_i  input  1  packet request valid.
- req_ready_o  output  1  request accepted when req_valid_i && req_ready_o.
- req_target_i  input  16  destination router address {x[7:0], y[7:0]}.
- req_size_i  input  FLIT_SIZE  payload flit count; 0 is legal.
- pl_valid_i  input  1  payload flit valid.
- pl_ready_o  output  1  payload flit consumed when pl_valid_i && pl_ready_o.
- pl_data_i  input  FLIT_SIZE  payload flit.
- tx_o  output  1  flit valid toward the router (router rx_i).
- credit_i  input  1  router has buffer space (router credit_o).
- data_o  output  FLIT_SIZE  flit toward the router.
- busy_o  output  1  high while a packet is incomplete (state != IDLE or tx_o high).
- pkt_sent_o  output  1  one-cycle pulse when the last flit of a packet is transferred.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- Reset values: tx_o=0, data_o=0, req_ready_o=1, pl_ready_o=0, busy_o=0, pkt_sent_o=0. State=IDLE, count=0, last_q=0.
- Link transfer occurs in a cycle where tx_o && credit_i. While credit_i=0, tx_o and data_o hold stable; no flit is dropped or duplicated.
- Output register (tx_o, data_o, last_q) holds one flit. slot_free = !tx_o || credit_i. A flit may be loaded only when slot_free; the load takes effect at the next edge.
- FSM states: IDLE, SIZE, PAYLOAD.
  - IDLE: req_ready_o = slot_free. On accept:
    - load header = {(FLIT_SIZE-16)'0, req_target_i};
    - latch size into count;
    - go to SIZE.
  - SIZE: when slot_free, load the size flit (count value).
    - If count==0: set last_q=1 and go to IDLE.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: pl_ready_o = slot_free (combinational, depends on credit_i). On payload accept:
    - load pl_data_i and decrement count;
    - if count==1, set last_q=1 and go to IDLE.
- Latency: header appears on tx_o the cycle after request accept. With credit_i held high and the payload always valid, flits are gapless; a packet of N payload flits occupies N+2 consecutive cycles.
- Back-to-back packets: in IDLE the next request may be accepted in the same cycle the previous last flit transfers. The new header then follows the previous last flit with no bubble.
- Payload bubbles (pl_valid_i=0): no load occurs. Once the held flit transfers, tx_o drops to 0; no garbage flit is sent.
- pkt_sent_o = tx_o && credit_i && last_q. last_q clears on any load of a non-last flit.
- Reset asserted mid-packet: the packet is abandoned and all state returns to reset values at the next edge. The router side must be reset together with this block.
- count width is FLIT_SIZE. No overflow is possible because count only decrements from the latched value.
- req_ready_o=0 and pl_ready_o=0 whenever their state does not permit acceptance. Inputs presented in the wrong state are ignored.

Decomposition:
- Add constant HERMES_TARGET_WIDTH = 16 to HermesPkg, shared with the switch's routing logic.
- FSM state enum stays local to this module.
- No sub-module: FSM, counter and single-flit output register fit in one module (~150 lines).

Test Plan:
- Basic packet, credit_i=1 always: target 0x0102, size 3, payload 0xA,0xB,0xC.
  -> data_o = 0x00000102, 0x3, 0xA, 0xB, 0xC on 5 consecutive cycles starting 1 cycle after accept.
  -> pkt_sent_o pulses once, in the 0xC cycle.
- Zero-length packet: target 0x0300, size 0.
  -> exactly 2 flits (0x00000300, 0x0); pkt_sent_o on the size flit; pl_ready_o never asserted.
- Credit stall: size 2; credit_i=0 for 4 cycles while the size flit is on data_o.
  -> data_o holds 0x2 with tx_o=1 for 4 cycles; pl_ready_o=0 throughout; then 2 payload flits, no loss or repeat.
- Payload bubbles: size 4; pl_valid_i toggles 1,0,1,0,...
  -> tx_o low in gap cycles; the 4 payload flits arrive in order; count reaches 0; return to IDLE.
- Back-to-back: two size-1 packets, req_valid_i held high.
  -> 6 consecutive tx_o cycles with no gap; pkt_sent_o pulses on flits 3 and 6.
- Reset mid-packet: rst_i=1 for 1 cycle during PAYLOAD of a size-5 packet.
  -> next cycle tx_o=0, busy_o=0, req_ready_o=1; a new packet then sends correctly from its header.
